apbmst: RTL

APBMST -- requirements
Module: apbmst

---
 rtl/apbmst_pkg.sv | 32 +++
 rtl/apbmst.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/apbmst_pkg.sv
// ---------------------------------------------------------------------------
// apbmst_pkg
// Shared definitions for the APB master bridge: the FSM state encoding,
// the default abort threshold for a stalled ACCESS phase, the default width
// of the wait counter, and a helper that word-aligns a byte address.
// ---------------------------------------------------------------------------
package apbmst_pkg;

  // Bridge FSM states. The numeric values are fixed so that debug probes
  // and other users of this package agree on the encoding.
  typedef enum logic [1:0] {
    P_IDLE   = 2'h0,
    P_SETUP  = 2'h1,
    P_ACCESS = 2'h2,
    P_RESP   = 2'h3
  } apbmst_state_e;

  // Default number of ACCESS cycles with PREADY low before the transfer is
  // abandoned and reported as an error.
  localparam int APBMST_TIMEOUT_CYCLES = 16;

  // Default wait counter width; it must be wide enough to hold the timeout
  // value itself, i.e. TIMEOUT_CYCLES < 2**TW.
  localparam int APBMST_TW = 5;

  // APB addresses are always word aligned, so the two byte-offset bits of
  // the requester's address are dropped.
  function automatic logic [31:0] apbmst_word_addr(input logic [31:0] byteAddr);
    return byteAddr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/apbmst.sv
// ---------------------------------------------------------------------------
// apbmst
// Single-transfer APB master. A command accepted on the valid/ready command
// port is turned into one APB SETUP + ACCESS sequence. The result comes back
// on a valid/ready response port. A slave that holds PREADY low for too long
// is abandoned, and that transfer is reported with RSP_ERR set.
//
// Ports
//   I_APBMST_PCLK        clock
//   I_APBMST_PRESET_N    asynchronous active-low reset
//   I_APBMST_CMD_VALID   command request
//   O_APBMST_CMD_READY   command accepted (high only in idle)
//   I_APBMST_CMD_WRITE   1 = write, 0 = read
//   I_APBMST_CMD_ADDR    byte address (aligned to a word on the APB side)
//   I_APBMST_CMD_WDATA   write data
//   O_APBMST_RSP_VALID   response available
//   I_APBMST_RSP_READY   response consumed
//   O_APBMST_RSP_RDATA   read data (zero for writes and for timeouts)
//   O_APBMST_RSP_ERR     timeout flag
//   O_APBMST_PADDR       APB address
//   O_APBMST_PWDATA      APB write data
//   O_APBMST_PWRITE      APB direction
//   O_APBMST_PSEL        APB select
//   O_APBMST_PENABLE     APB enable
//   I_APBMST_PRDATA      APB read data
//   I_APBMST_PREADY      APB ready (looked at only in ACCESS)
// ---------------------------------------------------------------------------
module apbmst
  import apbmst_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = APBMST_TIMEOUT_CYCLES,
  parameter int TW             = APBMST_TW
) (
  input  logic        I_APBMST_PCLK,
  input  logic        I_APBMST_PRESET_N,
  input  logic        I_APBMST_CMD_VALID,
  output logic        O_APBMST_CMD_READY,
  input  logic        I_APBMST_CMD_WRITE,
  input  logic [31:0] I_APBMST_CMD_ADDR,
  input  logic [31:0] I_APBMST_CMD_WDATA,
  output logic        O_APBMST_RSP_VALID,
  input  logic        I_APBMST_RSP_READY,
  output logic [31:0] O_APBMST_RSP_RDATA,
  output logic        O_APBMST_RSP_ERR,
  output logic [31:0] O_APBMST_PADDR,
  output logic [31:0] O_APBMST_PWDATA,
  output logic        O_APBMST_PWRITE,
  output logic        O_APBMST_PSEL,
  output logic        O_APBMST_PENABLE,
  input  logic [31:0] I_APBMST_PRDATA,
  input  logic        I_APBMST_PREADY
);

  apbmst_state_e state_q;
  logic          cmd_ready_q;
  logic          psel_q;
  logic          penable_q;
  logic          pwrite_q;
  logic [31:0]   paddr_q;
  logic [31:0]   pwdata_q;
  logic          rsp_valid_q;
  logic [31:0]   rsp_rdata_q;
  logic          rsp_err_q;
  logic [TW-1:0] wait_cnt_q;
  logic [TW-1:0] wait_cnt_d;
  logic          wait_expired;
  logic          cmd_accept;

  // Next value of the wait counter for an ACCESS cycle that sees PREADY low.
  // The transfer is abandoned in the same cycle that this value reaches the
  // threshold. So with PREADY held low, exactly TIMEOUT_CYCLES ACCESS cycles
  // are spent. A PREADY in that final cycle still wins.
  always_comb begin
    wait_cnt_d   = wait_cnt_q + TW'(1);
    wait_expired = (wait_cnt_d == TW'(TIMEOUT_CYCLES));
  end

  // CMD_READY is a register, so it stays low through reset. It first rises
  // on the clock after reset is released.
  assign cmd_accept = I_APBMST_CMD_VALID & cmd_ready_q;

  // Bridge FSM. Every output is registered here together with the state, so
  // the APB and response signals change only on clock edges, or at once
  // when reset is asserted.
  always_ff @(posedge I_APBMST_PCLK or negedge I_APBMST_PRESET_N) begin
    if (!I_APBMST_PRESET_N) begin
      state_q     <= P_IDLE;
      cmd_ready_q <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 32'h0;
      pwdata_q    <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      wait_cnt_q  <= '0;
    end else begin
      case (state_q)
        P_IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_accept) begin
            paddr_q     <= apbmst_word_addr(I_APBMST_CMD_ADDR);
            pwdata_q    <= I_APBMST_CMD_WDATA;
            pwrite_q    <= I_APBMST_CMD_WRITE;
            psel_q      <= 1'b1;
            penable_q   <= 1'b0;
            wait_cnt_q  <= '0;
            cmd_ready_q <= 1'b0;
            state_q     <= P_SETUP;
          end
        end

        P_SETUP: begin
          penable_q <= 1'b1;
          state_q   <= P_ACCESS;
        end

        // A ready slave takes priority over the timeout check. Write
        // responses carry zero data even if the slave drives PRDATA.
        P_ACCESS: begin
          if (I_APBMST_PREADY) begin
            rsp_rdata_q <= pwrite_q ? 32'h0 : I_APBMST_PRDATA;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            state_q     <= P_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            if (wait_expired) begin
              rsp_rdata_q <= 32'h0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= 1'b1;
              psel_q      <= 1'b0;
              penable_q   <= 1'b0;
              state_q     <= P_RESP;
            end
          end
        end

        P_RESP: begin
          if (I_APBMST_RSP_READY) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= P_IDLE;
          end
        end

        default: begin
          state_q <= P_IDLE;
        end
      endcase
    end
  end

  assign O_APBMST_CMD_READY = cmd_ready_q;
  assign O_APBMST_RSP_VALID = rsp_valid_q;
  assign O_APBMST_RSP_RDATA = rsp_rdata_q;
  assign O_APBMST_RSP_ERR   = rsp_err_q;
  assign O_APBMST_PADDR     = paddr_q;
  assign O_APBMST_PWDATA    = pwdata_q;
  assign O_APBMST_PWRITE    = pwrite_q;
  assign O_APBMST_PSEL      = psel_q;
  assign O_APBMST_PENABLE   = penable_q;

endmodule
